// File: rtl/stopwatch_lap_core.sv
// -----------------------------------------------------------------------------
// stopwatch_lap_core
//
// Stopwatch timing core. It keeps an MM:SS.CC BCD count with start/stop and
// clear controls. A small lap store holds DEPTH snapshots of the count, and a
// recall mode browses the stored laps on the display. It sits between the key
// debouncers, which supply single-cycle pulses, and the display serialiser.
//
// Parameters
//   TICK_DIV  sys_clk cycles per 0.01 s tick (>= 2)
//   DEPTH     lap entries, power of 2 in 2..64
//
// Build option
//   STOPWATCH_LAP_WRAP_EN  When defined, a store into a full lap store
//                          overwrites the oldest entry. When undefined, that
//                          store is ignored.
//
// Ports
//   sys_clk       in   system clock, rising edge
//   sys_rst_n     in   synchronous active-low reset
//   start_stop_p  in   pulse: toggle RUN/STOP
//   clear_p       in   pulse: zero count and empty lap store (STOP only)
//   store_p       in   pulse: push current count into lap store
//   read_p        in   pulse: enter / advance lap recall
//   disp_bcd      out  {m1,m0,s1,s0,c1,c0} shown on the display
//   disp_src      out  0 = live count, 1 = recalled lap
//   lap_idx       out  logical index of recalled lap (0 = oldest)
//   lap_cnt       out  number of laps held, 0..DEPTH
//   led           out  led[0] running, led[1] lap store full
// -----------------------------------------------------------------------------
module stopwatch_lap_core #(
    parameter int TICK_DIV = 500000,
    parameter int DEPTH    = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     start_stop_p,
    input  logic                     clear_p,
    input  logic                     store_p,
    input  logic                     read_p,
    output logic [23:0]              disp_bcd,
    output logic                     disp_src,
    output logic [$clog2(DEPTH)-1:0] lap_idx,
    output logic [$clog2(DEPTH):0]   lap_cnt,
    output logic [1:0]               led
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic { ST_STOP = 1'b0, ST_RUN    = 1'b1 } run_state_e;
    typedef enum logic { DS_LIVE = 1'b0, DS_RECALL = 1'b1 } disp_state_e;

    // Add one centisecond to a packed BCD time. Each digit rolls over at its
    // own limit and passes the carry up: c0/c1/s0/m0 at 9, s1/m1 at 5.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[i*4 +: 4] == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    run_state_e  run_q,      run_d;
    disp_state_e disp_q,     disp_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [23:0]   count_q,  count_d;
    logic [AW-1:0] base_q,   base_d;     // physical slot of the oldest lap
    logic [AW:0]   cnt_q,    cnt_d;
    logic [AW-1:0] idx_q,    idx_d;
    logic [23:0]   disp_bcd_q, disp_bcd_d;
    logic [1:0]    led_q,    led_d;

    logic [23:0]   lap_ram_q [DEPTH];
    logic          lap_we;
    logic [AW-1:0] lap_waddr;
    logic [AW-1:0] lap_raddr;
    logic          tick;
    logic          full;

    // NOTE: every signal assigned here gets a default value first. Otherwise
    // a path that skips an assignment would infer a latch.
    always_comb begin
        run_d     = run_q;
        disp_d    = disp_q;
        presc_d   = presc_q;
        count_d   = count_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lap_we    = 1'b0;
        // The next free slot follows the oldest entry. When the store is full
        // the low bits of cnt_q are zero, so this address is the oldest slot.
        lap_waddr = base_q + cnt_q[AW-1:0];

        tick = (run_q == ST_RUN) && (presc_q == PRESC_MAX);
        full = (cnt_q == CNT_FULL);

        // Timebase. A stop pulse takes effect from the next cycle, so a tick
        // that lands on the same cycle as the stop pulse still counts.
        if (run_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                count_d = bcd_inc(count_q);
            end
        end

        // Pulses are arbitrated first and only the winner is acted on.
        // A clear that loses to RUN mode still suppresses lower pulses.
        if (clear_p) begin
            if (run_q == ST_STOP) begin
                count_d = '0;
                presc_d = '0;
                cnt_d   = '0;
                base_d  = '0;
                idx_d   = '0;
                disp_d  = DS_LIVE;
            end
        end else if (start_stop_p) begin
            disp_d = DS_LIVE;
            idx_d  = '0;
            if (run_q == ST_STOP) begin
                run_d   = ST_RUN;
                presc_d = '0;
            end else begin
                run_d = ST_STOP;
            end
        end else if (store_p) begin
            disp_d = DS_LIVE;
            idx_d  = '0;
            if (!full) begin
                lap_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
            end else begin
`ifdef STOPWATCH_LAP_WRAP_EN
                // Overwrite the oldest slot. The next entry becomes the oldest.
                lap_we = 1'b1;
                base_d = base_q + 1'b1;
`else
                lap_we = 1'b0;
`endif
            end
        end else if (read_p && (cnt_q != '0)) begin
            if (disp_q == DS_LIVE) begin
                disp_d = DS_RECALL;
                idx_d  = '0;
            end else begin
                idx_d = ({1'b0, idx_q} == cnt_q - 1'b1) ? '0 : idx_q + 1'b1;
            end
        end

        // The display and LEDs come from next-state values. They then change
        // on the same edge as the count, the mode and the index.
        lap_raddr  = base_d + idx_d;
        disp_bcd_d = (disp_d == DS_RECALL) ? lap_ram_q[lap_raddr] : count_d;
        led_d      = {cnt_d == CNT_FULL, run_d == ST_RUN};
    end

    // NOTE: state registers use non-blocking assignment, so every flop
    // samples the values from before this edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            run_q      <= ST_STOP;
            disp_q     <= DS_LIVE;
            presc_q    <= '0;
            count_q    <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_bcd_q <= '0;
            led_q      <= '0;
        end else begin
            run_q      <= run_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_bcd_q <= disp_bcd_d;
            led_q      <= led_d;
        end
    end

    // NOTE: the lap RAM has no reset. Entries are only read when cnt_q marks
    // them valid, so reset only blocks the write. That block prevents a
    // partial store when reset arrives together with store_p.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && lap_we) begin
            lap_ram_q[lap_waddr] <= count_q;
        end
    end

    assign disp_bcd = disp_bcd_q;
    assign disp_src = disp_q;
    assign lap_idx  = idx_q;
    assign lap_cnt  = cnt_q;
    assign led      = led_q;

endmodule
